// File: rtl/game_pkg.sv
// Shared encodings for the match sequencer: action codes, FSM states,
// winner codes, button bit positions and the bus widths used by the core.
package game_pkg;

  localparam int unsigned ACT_W   = 3;
  localparam int unsigned BTN_W   = 6;
  localparam int unsigned HP_W    = 2;
  localparam int unsigned TIMER_W = 6;
  localparam int unsigned ROUND_W = 3;
  localparam int unsigned WINS_W  = 2;
  localparam int unsigned PH_W    = 3;

  // Button bit positions within p*_btn
  localparam int unsigned BTN_BACK  = 0;
  localparam int unsigned BTN_FWD   = 1;
  localparam int unsigned BTN_JUMP  = 2;
  localparam int unsigned BTN_WAIT  = 3;
  localparam int unsigned BTN_PUNCH = 4;
  localparam int unsigned BTN_KICK  = 5;

  typedef enum logic [ACT_W-1:0] {
    ACT_WAIT  = 3'd0,
    ACT_FWD   = 3'd1,
    ACT_BACK  = 3'd2,
    ACT_JUMP  = 3'd3,
    ACT_PUNCH = 3'd4,
    ACT_KICK  = 3'd5
  } action_e;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_INTRO      = 3'd1,
    ST_FIGHT      = 3'd2,
    ST_KO         = 3'd3,
    ST_ROUND_END  = 3'd4,
    ST_MATCH_OVER = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_e;

  // Fixed-priority button encoder: kick > punch > jump > back > forward > waiting
  function automatic action_e encode_buttons(input logic [BTN_W-1:0] btn);
    action_e act;
    act = ACT_WAIT;
    if (btn[BTN_KICK])       act = ACT_KICK;
    else if (btn[BTN_PUNCH]) act = ACT_PUNCH;
    else if (btn[BTN_JUMP])  act = ACT_JUMP;
    else if (btn[BTN_BACK])  act = ACT_BACK;
    else if (btn[BTN_FWD])   act = ACT_FWD;
    else if (btn[BTN_WAIT])  act = ACT_WAIT;
    return act;
  endfunction

  // Larger value wins; equal values are a draw (used for health and wins)
  function automatic winner_e compare_score(input logic [1:0] a, input logic [1:0] b);
    winner_e res;
    res = WIN_DRAW;
    if (a > b)      res = WIN_P1;
    else if (b > a) res = WIN_P2;
    return res;
  endfunction

endpackage

// File: rtl/game_round_ctrl_if.sv
// Pad/core-facing bundle of the match sequencer.
//   p1_btn/p2_btn       : raw player buttons (from pads)
//   p1_health/p2_health : health levels (from core)
//   p1_action/p2_action : registered action codes (to core)
//   action_valid        : actions are live (to core)
//   core_rst_n          : active-low core reset (to core)
// master = sequencer side, slave = pads/core side.
interface game_round_ctrl_if;
  import game_pkg::*;

  logic [BTN_W-1:0] p1_btn;
  logic [BTN_W-1:0] p2_btn;
  logic [HP_W-1:0]  p1_health;
  logic [HP_W-1:0]  p2_health;
  logic [ACT_W-1:0] p1_action;
  logic [ACT_W-1:0] p2_action;
  logic             action_valid;
  logic             core_rst_n;

  modport master (
    input  p1_btn, p2_btn, p1_health, p2_health,
    output p1_action, p2_action, action_valid, core_rst_n
  );

  modport slave (
    output p1_btn, p2_btn, p1_health, p2_health,
    input  p1_action, p2_action, action_valid, core_rst_n
  );

endinterface

// File: rtl/game_action_arb.sv
// Per-player action arbiter: priority-encodes the button set into a
// registered action code and blocks the player for COOLDOWN cycles after
// a PUNCH or KICK.
//   clk, rst_n : clock, async active-low reset
//   en         : high when the next cycle is a FIGHT cycle
//   btn        : raw button set
//   action     : registered action code (0 when not enabled)
module game_action_arb
  import game_pkg::*;
#(
  parameter int unsigned COOLDOWN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [BTN_W-1:0] btn,
  output logic [ACT_W-1:0] action
);

  localparam int unsigned CD_W = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);

  logic [CD_W-1:0] cd_cnt;
  action_e         pick_c;

  assign pick_c = encode_buttons(btn);

  // Action register and cooldown; disabled cycles clear the cooldown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      action <= ACT_W'(ACT_WAIT);
      cd_cnt <= '0;
    end else if (!en) begin
      action <= ACT_W'(ACT_WAIT);
      cd_cnt <= '0;
    end else if (cd_cnt != '0) begin
      action <= ACT_W'(ACT_WAIT);
      cd_cnt <= cd_cnt - CD_W'(1);
    end else begin
      action <= ACT_W'(pick_c);
      if (pick_c == ACT_PUNCH || pick_c == ACT_KICK) begin
        cd_cnt <= CD_W'(COOLDOWN);
      end
    end
  end

endmodule

// File: rtl/game_round_ctrl.sv
// Match sequencer for the two-player fighting-game core: holds the core in
// reset between rounds, times each round, scores KO/time-out results and
// declares the match winner. Action arbitration lives in game_action_arb.
//   CLK, RST_N : clock, async active-low reset
//   start      : starts a match (IDLE / MATCH_OVER only)
//   gif        : pad/core bundle (buttons, health, actions, core reset)
//   state      : FSM state code
//   timer      : remaining FIGHT ticks
//   round_num  : current round, 1-based (0 in IDLE)
//   p1_wins/p2_wins : round wins per player
//   winner     : match result 00 none, 01 P1, 10 P2, 11 draw
module game_round_ctrl
  import game_pkg::*;
#(
  parameter int unsigned ROUND_TICKS  = 60,
  parameter int unsigned INTRO_CYCLES = 2,
  parameter int unsigned SHOW_CYCLES  = 4,
  parameter int unsigned WINS_TO_WIN  = 2,
  parameter int unsigned MAX_ROUNDS   = 5,
  parameter int unsigned COOLDOWN     = 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               start,
  game_round_ctrl_if.master  gif,
  output logic [2:0]         state,
  output logic [TIMER_W-1:0] timer,
  output logic [ROUND_W-1:0] round_num,
  output logic [WINS_W-1:0]  p1_wins,
  output logic [WINS_W-1:0]  p2_wins,
  output logic [1:0]         winner
);

  state_e           st_q;
  logic [PH_W-1:0]  phase_q;
  winner_e          round_res_q;

  logic    p1_ko_c;
  logic    p2_ko_c;
  logic    end_round_c;
  logic    intro_done_c;
  logic    show_done_c;
  logic    match_done_c;
  logic    fight_next_c;
  winner_e round_res_c;

  assign state = 3'(st_q);

  assign p1_ko_c      = (gif.p1_health == '0);
  assign p2_ko_c      = (gif.p2_health == '0);
  assign end_round_c  = p1_ko_c || p2_ko_c || (timer == TIMER_W'(1));
  assign intro_done_c = (phase_q == PH_W'(INTRO_CYCLES - 1));
  assign show_done_c  = (phase_q == PH_W'(SHOW_CYCLES - 1));
  assign match_done_c = (p1_wins == WINS_W'(WINS_TO_WIN)) ||
                        (p2_wins == WINS_W'(WINS_TO_WIN)) ||
                        (round_num == ROUND_W'(MAX_ROUNDS));

  // Next cycle is a FIGHT cycle: lets registered actions line up with state
  assign fight_next_c = (st_q == ST_INTRO && intro_done_c) ||
                        (st_q == ST_FIGHT && !end_round_c);

  // Round outcome; a zero health always counts as KO, even on time-out
  always_comb begin
    round_res_c = WIN_DRAW;
    if (p1_ko_c && p2_ko_c) round_res_c = WIN_DRAW;
    else if (p1_ko_c)       round_res_c = WIN_P2;
    else if (p2_ko_c)       round_res_c = WIN_P1;
    else                    round_res_c = compare_score(gif.p1_health, gif.p2_health);
  end

  // Match FSM with timer, score and core-reset registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_q             <= ST_IDLE;
      phase_q          <= '0;
      round_res_q      <= WIN_NONE;
      timer            <= '0;
      round_num        <= '0;
      p1_wins          <= '0;
      p2_wins          <= '0;
      winner           <= 2'(WIN_NONE);
      gif.core_rst_n   <= 1'b0;
      gif.action_valid <= 1'b0;
    end else begin
      gif.action_valid <= fight_next_c;
      case (st_q)
        ST_IDLE, ST_MATCH_OVER: begin
          if (start) begin
            p1_wins        <= '0;
            p2_wins        <= '0;
            winner         <= 2'(WIN_NONE);
            round_num      <= ROUND_W'(1);
            phase_q        <= '0;
            gif.core_rst_n <= 1'b0;
            st_q           <= ST_INTRO;
          end
        end
        ST_INTRO: begin
          timer <= TIMER_W'(ROUND_TICKS);
          if (intro_done_c) begin
            gif.core_rst_n <= 1'b1;
            st_q           <= ST_FIGHT;
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        ST_FIGHT: begin
          timer <= timer - TIMER_W'(1);
          if (end_round_c) begin
            round_res_q <= round_res_c;
            st_q        <= ST_KO;
          end
        end
        ST_KO: begin
          if (round_res_q == WIN_P1 && p1_wins < WINS_W'(WINS_TO_WIN)) begin
            p1_wins <= p1_wins + WINS_W'(1);
          end
          if (round_res_q == WIN_P2 && p2_wins < WINS_W'(WINS_TO_WIN)) begin
            p2_wins <= p2_wins + WINS_W'(1);
          end
          phase_q <= '0;
          st_q    <= ST_ROUND_END;
        end
        ST_ROUND_END: begin
          if (show_done_c) begin
            if (match_done_c) begin
              winner <= 2'(compare_score(p1_wins, p2_wins));
              st_q   <= ST_MATCH_OVER;
            end else begin
              if (round_num < ROUND_W'(MAX_ROUNDS)) begin
                round_num <= round_num + ROUND_W'(1);
              end
              phase_q        <= '0;
              gif.core_rst_n <= 1'b0;
              st_q           <= ST_INTRO;
            end
          end else begin
            phase_q <= phase_q + PH_W'(1);
          end
        end
        default: st_q <= ST_IDLE;
      endcase
    end
  end

  game_action_arb #(.COOLDOWN(COOLDOWN)) u_p1_arb (
    .clk    (CLK),
    .rst_n  (RST_N),
    .en     (fight_next_c),
    .btn    (gif.p1_btn),
    .action (gif.p1_action)
  );

  game_action_arb #(.COOLDOWN(COOLDOWN)) u_p2_arb (
    .clk    (CLK),
    .rst_n  (RST_N),
    .en     (fight_next_c),
    .btn    (gif.p2_btn),
    .action (gif.p2_action)
  );

endmodule

// File: tb/tb_game_round_ctrl.sv
// Directed bench for game_round_ctrl: start/intro timing, action priority
// and cooldown, KO and time-out scoring, async reset, and a five-draw match.
module tb_game_round_ctrl;
  import game_pkg::*;

  logic       CLK   = 1'b0;
  logic       RST_N = 1'b0;
  logic       start = 1'b0;
  logic [2:0] state;
  logic [5:0] timer;
  logic [2:0] round_num;
  logic [1:0] p1_wins;
  logic [1:0] p2_wins;
  logic [1:0] winner;

  int errors = 0;
  int checks = 0;
  int n;

  game_round_ctrl_if gif();

  game_round_ctrl dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .start     (start),
    .gif       (gif),
    .state     (state),
    .timer     (timer),
    .round_num (round_num),
    .p1_wins   (p1_wins),
    .p2_wins   (p2_wins),
    .winner    (winner)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    gif.p1_btn    = 6'b000000;
    gif.p2_btn    = 6'b000000;
    gif.p1_health = 2'd3;
    gif.p2_health = 2'd3;

    // Reset state
    repeat (2) tick();
    check("rst_state", 32'(state), 0);
    check("rst_core_rst_n", 32'(gif.core_rst_n), 0);
    check("rst_valid", 32'(gif.action_valid), 0);
    check("rst_timer", 32'(timer), 0);
    check("rst_round", 32'(round_num), 0);
    check("rst_winner", 32'(winner), 0);
    RST_N = 1'b1;
    tick();
    check("idle_hold", 32'(state), 0);

    // Start -> two INTRO cycles -> FIGHT
    start = 1'b1;
    tick();
    start = 1'b0;
    check("intro1_state", 32'(state), 1);
    check("intro1_round", 32'(round_num), 1);
    check("intro1_core_rst", 32'(gif.core_rst_n), 0);
    check("intro1_valid", 32'(gif.action_valid), 0);
    tick();
    check("intro2_state", 32'(state), 1);
    check("intro2_core_rst", 32'(gif.core_rst_n), 0);
    tick();
    check("fight_state", 32'(state), 2);
    check("fight_timer", 32'(timer), 60);
    check("fight_core_rst", 32'(gif.core_rst_n), 1);
    check("fight_valid", 32'(gif.action_valid), 1);
    check("fight_round", 32'(round_num), 1);

    // Priority and cooldown
    gif.p1_btn = 6'b110010;
    tick();
    check("kick_p1", 32'(gif.p1_action), 5);
    check("kick_p2", 32'(gif.p2_action), 0);
    check("kick_timer", 32'(timer), 59);
    tick();
    check("kick_cooldown", 32'(gif.p1_action), 0);
    tick();
    check("kick_again", 32'(gif.p1_action), 5);
    gif.p1_btn = 6'b010100;
    tick();
    check("punch_cd", 32'(gif.p1_action), 0);
    tick();
    check("punch_over_jump", 32'(gif.p1_action), 4);
    gif.p1_btn = 6'b000111;
    tick();
    check("punch_cooldown", 32'(gif.p1_action), 0);
    tick();
    check("jump_over_back", 32'(gif.p1_action), 3);
    gif.p1_btn = 6'b000011;
    gif.p2_btn = 6'b100000;
    tick();
    check("back_over_fwd", 32'(gif.p1_action), 2);
    check("p2_kick", 32'(gif.p2_action), 5);
    gif.p1_btn = 6'b001010;
    tick();
    check("fwd_over_wait", 32'(gif.p1_action), 1);
    check("p2_cooldown", 32'(gif.p2_action), 0);
    gif.p1_btn = 6'b001000;
    gif.p2_btn = 6'b000000;
    tick();
    check("wait_btn", 32'(gif.p1_action), 0);
    check("timer_50", 32'(timer), 50);

    // Round 1: P2 KO
    gif.p2_health = 2'd0;
    tick();
    check("ko_state", 32'(state), 3);
    check("ko_valid", 32'(gif.action_valid), 0);
    check("ko_timer", 32'(timer), 49);
    gif.p2_health = 2'd3;
    gif.p1_btn    = 6'b100000;
    tick();
    check("re1_state", 32'(state), 4);
    check("re1_p1_wins", 32'(p1_wins), 1);
    check("re1_p2_wins", 32'(p2_wins), 0);
    check("re1_action", 32'(gif.p1_action), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("re1_hold", 32'(state), 4);
    end
    tick();
    check("r2_intro", 32'(state), 1);
    check("r2_round", 32'(round_num), 2);
    check("r2_core_rst", 32'(gif.core_rst_n), 0);
    repeat (2) tick();
    check("r2_fight", 32'(state), 2);

    // Round 2: P2 KO again -> match over
    gif.p2_health = 2'd0;
    tick();
    check("r2_ko", 32'(state), 3);
    gif.p2_health = 2'd3;
    tick();
    check("r2_p1_wins", 32'(p1_wins), 2);
    repeat (3) tick();
    check("r2_re_hold", 32'(state), 4);
    tick();
    check("mo_state", 32'(state), 5);
    check("mo_winner", 32'(winner), 1);
    check("mo_p1_wins", 32'(p1_wins), 2);
    check("mo_action", 32'(gif.p1_action), 0);
    check("mo_valid", 32'(gif.action_valid), 0);
    check("mo_core_rst", 32'(gif.core_rst_n), 1);
    repeat (2) tick();
    check("mo_hold_state", 32'(state), 5);
    check("mo_hold_winner", 32'(winner), 1);

    // New match; round 1 double KO draw
    gif.p1_btn = 6'b000000;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("m2_state", 32'(state), 1);
    check("m2_winner", 32'(winner), 0);
    check("m2_p1_wins", 32'(p1_wins), 0);
    check("m2_round", 32'(round_num), 1);
    repeat (2) tick();
    gif.p1_health = 2'd0;
    gif.p2_health = 2'd0;
    tick();
    check("dko_state", 32'(state), 3);
    gif.p1_health = 2'd3;
    gif.p2_health = 2'd3;
    tick();
    check("dko_p1_wins", 32'(p1_wins), 0);
    check("dko_p2_wins", 32'(p2_wins), 0);
    repeat (4) tick();
    check("dko_next_state", 32'(state), 1);
    check("dko_next_round", 32'(round_num), 2);

    // Round 2: time-out, P2 healthier
    repeat (2) tick();
    check("to_fight_timer", 32'(timer), 60);
    gif.p1_health = 2'd2;
    gif.p2_health = 2'd3;
    repeat (59) tick();
    check("to_last_state", 32'(state), 2);
    check("to_last_timer", 32'(timer), 1);
    tick();
    check("to_ko_state", 32'(state), 3);
    check("to_ko_timer", 32'(timer), 0);
    tick();
    check("to_p2_wins", 32'(p2_wins), 1);
    check("to_p1_wins", 32'(p1_wins), 0);
    repeat (4) tick();
    check("r3_round", 32'(round_num), 3);

    // Round 3: time-out with equal health is a draw
    gif.p1_health = 2'd3;
    repeat (2) tick();
    repeat (60) tick();
    check("eq_ko_state", 32'(state), 3);
    tick();
    check("eq_p1_wins", 32'(p1_wins), 0);
    check("eq_p2_wins", 32'(p2_wins), 1);
    repeat (4) tick();
    check("r4_round", 32'(round_num), 4);

    // Round 4: start ignored in FIGHT, then async reset mid-FIGHT
    repeat (2) tick();
    check("r4_fight", 32'(state), 2);
    start = 1'b1;
    gif.p1_btn = 6'b000100;
    repeat (2) tick();
    check("start_ignored", 32'(state), 2);
    check("r4_jump", 32'(gif.p1_action), 3);
    start = 1'b0;
    RST_N = 1'b0;
    #1;
    check("arst_state", 32'(state), 0);
    check("arst_action", 32'(gif.p1_action), 0);
    check("arst_valid", 32'(gif.action_valid), 0);
    check("arst_core_rst", 32'(gif.core_rst_n), 0);
    check("arst_timer", 32'(timer), 0);
    check("arst_round", 32'(round_num), 0);
    check("arst_p2_wins", 32'(p2_wins), 0);
    #2;
    RST_N = 1'b1;
    tick();
    check("post_rst_idle", 32'(state), 0);

    // Five straight draws -> MATCH_OVER with draw result
    gif.p1_btn    = 6'b000000;
    gif.p1_health = 2'd0;
    gif.p2_health = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (state != 3'd5 && n < 100) begin
      tick();
      n++;
    end
    check("draw5_cycles", 32'(n), 40);
    check("draw5_state", 32'(state), 5);
    check("draw5_winner", 32'(winner), 3);
    check("draw5_round", 32'(round_num), 5);
    check("draw5_p1_wins", 32'(p1_wins), 0);
    check("draw5_p2_wins", 32'(p2_wins), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/game_round_ctrl.md
Name: game_round_ctrl

Overview:
- Match sequencer for the two-player fighting-game core. Turns each player's raw button set into one registered action code per cycle, with fixed priority and a post-attack cooldown.
- Holds the core in reset between rounds and times each round.
- Detects KO or time-out from the core's health outputs, keeps a win count per player, and declares the match winner.
- Sits between the player input pads and the game core.

Parameters:
- ROUND_TICKS, 60, FIGHT cycles per round before time-out.
- INTRO_CYCLES, 2, cycles core_rst_n is held low before each round.
- SHOW_CYCLES, 4, cycles spent in ROUND_END before the next round.
- WINS_TO_WIN, 2, round wins needed to take the match.
- MAX_ROUNDS, 5, round cap; the match ends after this many rounds even if no one has reached WINS_TO_WIN.
- COOLDOWN, 1, cycles a player's action is forced to WAIT after a PUNCH or KICK.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- start  in  1  starts a match; sampled only in IDLE and MATCH_OVER.
- p1_btn  in  6  player 1 buttons {kick,punch,waiting,jump,forward,back}, bit5 = kick.
- p2_btn  in  6  player 2 buttons, same layout.
- p1_health  in  2  player 1 health from the core.
- p2_health  in  2  player 2 health from the core.
- p1_action  out  3  encoded action: 0 WAIT, 1 FWD, 2 BACK, 3 JUMP, 4 PUNCH, 5 KICK.
- p2_action  out  3  same encoding for player 2.
- action_valid  out  1  high while actions are being issued to the core.
- core_rst_n  out  1  active-low reset to the game core.
- state  out  3  0 IDLE, 1 INTRO, 2 FIGHT, 3 KO, 4 ROUND_END, 5 MATCH_OVER.
- timer  out  6  remaining FIGHT ticks.
- round_num  out  3  current round, 1-based; 0 in IDLE.
- p1_wins  out  2  round wins for player 1.
- p2_wins  out  2  round wins for player 2.
- winner  out  2  match result: 00 none, 01 P1, 10 P2, 11 draw.

Behaviour:

Reset (async, RST_N=0):
- state=IDLE.
- Actions=0, action_valid=0, core_rst_n=0.
- timer=0, round_num=0, wins=0, winner=00.
- Cooldown counters=0.
- Reset asserted mid-match aborts immediately to these values.

Action arbitration (registered):
- Buttons sampled at edge N produce the action visible after edge N, i.e. 1-cycle latency.
- Priority: kick > punch > jump > back > forward > waiting. No button pressed gives WAIT.
- Both players are arbitrated independently, every cycle.
- After a PUNCH or KICK is issued, that player's next COOLDOWN cycles output WAIT and buttons are ignored.
- Outside FIGHT: actions are forced to 0 and action_valid=0.
- Cooldown counters clear on INTRO entry.

FSM transitions:
- IDLE:
  - On start=1: clear wins and winner, set round_num=1, go to INTRO.
- INTRO:
  - core_rst_n=0 for INTRO_CYCLES cycles.
  - Load timer=ROUND_TICKS.
  - Go to FIGHT.
  - core_rst_n=1 in every state except IDLE and INTRO.
- FIGHT:
  - action_valid=1.
  - timer decrements by 1 each cycle.
  - Go to KO when either health==0, or timer==1 as it decrements to 0.
  - Round result is latched on the transition into KO:
    - Exactly one health==0: the other player wins the round.
    - Both healths==0 in the same cycle: draw.
    - Time-out with neither health==0: higher health wins; equal health is a draw.
  - A health==0 in the time-out cycle is treated as a KO.
- KO (1 cycle):
  - Increment the round winner's win count; a draw increments neither.
- ROUND_END:
  - Hold for SHOW_CYCLES cycles.
  - If either wins==WINS_TO_WIN, or round_num==MAX_ROUNDS: go to MATCH_OVER.
  - Otherwise: round_num+1, go to INTRO.
- MATCH_OVER:
  - winner is set from the win counts: higher count wins; equal counts give 11.
  - winner holds until start=1, which is treated like start in IDLE: clear wins and winner, round_num=1, go to INTRO.

Ignored and saturating cases:
- start is ignored in INTRO, FIGHT, KO and ROUND_END.
- Win counters never exceed WINS_TO_WIN.
- round_num never exceeds MAX_ROUNDS.

Decomposition:
- Package game_pkg holds:
  - The action encoding constants.
  - The state encoding.
  - The winner codes.
  - The button bit indices.
- One sub-module, game_action_arb, instantiated once per player: priority encoder plus cooldown counter, with a FIGHT-enable input.
- The top level holds the FSM, timer and score counters.

Test Plan:
1. Reset release, start=1 for 1 cycle -> state goes IDLE→INTRO; core_rst_n=0 for 2 cycles; then FIGHT with timer=60, round_num=1.
2. In FIGHT, p1_btn=kick+punch+forward, p2_btn=000000 -> next cycle p1_action=5, p2_action=0; the cycle after with kick still held -> p1_action=0 (cooldown); the following cycle -> 5.
3. p2_health driven to 0 in round 1 -> KO; p1_wins=1; ROUND_END for 4 cycles; INTRO with round_num=2. Repeat the KO -> MATCH_OVER with winner=01, p1_wins=2, actions 0, action_valid=0.
4. Both healths driven to 0 in the same cycle -> draw: neither win count changes; round_num advances.
5. No KO for 60 FIGHT cycles, p1_health=2, p2_health=3 -> time-out gives p2_wins+1; with equal health, a draw.
6. RST_N pulsed low mid-FIGHT -> all outputs return to reset values asynchronously; start is ignored during FIGHT; 5 straight draws -> MATCH_OVER with winner=11.
